// File: rtl/unmix_1024.sv
// Inverse Threefish-1024 MIX layer for the decrypt path: undoes the eight word-pair
// MIX operations of one round, PAIRS_PER_CYCLE pairs per clock.
module unmix_1024 #(
    parameter int PAIRS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    d,
    input  logic [1023:0] state_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] state_out
);
    // state | meaning
    // IDLE  | waiting for a state, in_ready high
    // BUSY  | inverting pair groups in the working register
    // DONE  | result presented, waiting for out_ready

    localparam int         NPAIR    = 8;
    localparam logic [3:0] CNT_STEP = 4'(PAIRS_PER_CYCLE);
    localparam logic [3:0] CNT_LAST = 4'(NPAIR - PAIRS_PER_CYCLE);

    localparam int ROT [8][8] = '{
        '{55, 43, 37, 40, 16, 22, 38, 12},
        '{25, 25, 46, 13, 14, 13, 52, 57},
        '{33,  8, 18, 57, 21, 12, 32, 54},
        '{34, 43, 25, 60, 44,  9, 59, 34},
        '{28,  7, 47, 48, 51,  9, 35, 41},
        '{17,  6, 18, 25, 43, 42, 40, 15},
        '{58,  7, 32, 45, 19, 18,  2, 56},
        '{47, 49, 27, 58, 37, 48, 53, 56}
    };

    if (PAIRS_PER_CYCLE != 1 && PAIRS_PER_CYCLE != 2 &&
        PAIRS_PER_CYCLE != 4 && PAIRS_PER_CYCLE != 8) begin : g_bad_ppc
        $error("unmix_1024: PAIRS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_nxt;
    logic [1023:0]   work, work_nxt, out_q;
    logic [3:0]      cnt;
    logic [2:0]      rnd;
    logic            accept, last_grp, drain;
    logic            unused_d_hi;

    assign unused_d_hi = ^d[7:3];

    // Doubling the word makes a plain right shift act as a rotate; R=0 is identity.
    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] r);
        logic [127:0] t;
        t = {x, x} >> r;
        return t[63:0];
    endfunction

    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign last_grp = (state_q == BUSY) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept)   state_nxt = BUSY;
            BUSY:    if (last_grp) state_nxt = DONE;
            DONE:    if (drain)    state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Every pair is evaluated each clock; only the current group is written back.
    always_comb begin : p_inv
        logic [63:0] y0, y1, x0, x1;
        y0       = '0;
        y1       = '0;
        x0       = '0;
        x1       = '0;
        work_nxt = work;
        for (int j = 0; j < NPAIR; j++) begin
            y0 = work[128*j +: 64];
            y1 = work[128*j+64 +: 64];
            x1 = ror64(y1 ^ y0, 6'(ROT[rnd][j]));
            x0 = y0 - x1;
            if (state_q == BUSY && 4'(j) >= cnt && 4'(j) < cnt + CNT_STEP) begin
                work_nxt[128*j +: 64]    = x0;
                work_nxt[128*j+64 +: 64] = x1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            out_q <= '0;
            cnt   <= '0;
            rnd   <= '0;
        end else if (accept) begin
            work <= state_in;
            rnd  <= d[2:0];
            cnt  <= '0;
        end else if (state_q == BUSY) begin
            work <= work_nxt;
            cnt  <= cnt + CNT_STEP;
            if (last_grp) out_q <= work_nxt;
        end
    end

    assign state_out = out_q;

endmodule

// File: tb/tb_unmix_1024.sv
// Bench for unmix_1024: four instances (1, 2, 4, 8 pairs per clock) share stimulus and
// are checked against constants and a forward-MIX model for round-trip identity.
module tb_unmix_1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [7:0]    d;
    logic [1023:0] state_in;
    logic [3:0]    in_ready;
    logic [3:0]    out_valid;
    logic [1023:0] state_out [4];

    logic [1023:0] res_q [4];
    int            lat_q [4];
    int            n_checks = 0;
    int            n_pass   = 0;

    localparam int ROT_T [8][8] = '{
        '{55, 43, 37, 40, 16, 22, 38, 12},
        '{25, 25, 46, 13, 14, 13, 52, 57},
        '{33,  8, 18, 57, 21, 12, 32, 54},
        '{34, 43, 25, 60, 44,  9, 59, 34},
        '{28,  7, 47, 48, 51,  9, 35, 41},
        '{17,  6, 18, 25, 43, 42, 40, 15},
        '{58,  7, 32, 45, 19, 18,  2, 56},
        '{47, 49, 27, 58, 37, 48, 53, 56}
    };

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        unmix_1024 #(.PAIRS_PER_CYCLE(1 << i)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[i]),
            .d         (d),
            .state_in  (state_in),
            .out_valid (out_valid[i]),
            .out_ready (out_ready),
            .state_out (state_out[i])
        );
    end

    function automatic logic [63:0] rol(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    // Forward Threefish MIX: y0 = x0 + x1, y1 = rol(x1, R) ^ y0.
    function automatic logic [1023:0] fwd_mix(input logic [1023:0] s, input logic [2:0] row);
        logic [1023:0] o;
        logic [63:0]   x0, x1, y0;
        o = s;
        for (int j = 0; j < 8; j++) begin
            x0 = s[128*j +: 64];
            x1 = s[128*j+64 +: 64];
            y0 = x0 + x1;
            o[128*j +: 64]    = y0;
            o[128*j+64 +: 64] = rol(x1, ROT_T[row][j]) ^ y0;
        end
        return o;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Drives one state in and records each instance's first-valid result and latency.
    task automatic run_txn(input logic [7:0] dd, input logic [1023:0] s, input logic hold);
        int         cyc;
        logic [3:0] seen;
        cyc = 0;
        while (in_ready !== 4'hF && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (in_ready !== 4'hF) $display("FAIL txn_idle in_ready=%b required=1111", in_ready);
        else n_pass++;
        out_ready = !hold;
        in_valid  = 1'b1;
        d         = dd;
        state_in  = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        d        = 8'($urandom);
        state_in = rand1024();
        seen     = '0;
        cyc      = 0;
        for (int i = 0; i < 4; i++) lat_q[i] = -1;
        while (seen !== 4'hF && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && out_valid[i]) begin
                    seen[i]  = 1'b1;
                    lat_q[i] = cyc;
                    res_q[i] = state_out[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        d         = '0;
        state_in  = '0;
        #12;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready[i] !== 1'b1) $display("FAIL reset_in_ready[%0d] got=%b want=1", i, in_ready[i]);
            else n_pass++;
            n_checks++;
            if (out_valid[i] !== 1'b0) $display("FAIL reset_out_valid[%0d] got=%b want=0", i, out_valid[i]);
            else n_pass++;
            n_checks++;
            if (state_out[i] !== '0) $display("FAIL reset_state_out[%0d] got=%h want=0", i, state_out[i]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1023:0] s, e;
        logic [7:0]    dd;
        for (int v = 0; v < 5; v++) begin
            s = '0;
            e = '0;
            case (v)
                0: begin dd = 8'd0; s[63:0] = 64'd1; s[127:64] = 64'd1;                    e[63:0] = 64'd1; end
                1: begin dd = 8'd0; s[63:0] = 64'd1; s[127:64] = 64'h0080_0000_0000_0001; e[127:64] = 64'd1; end
                2: begin dd = 8'd8; s[63:0] = 64'd1; s[127:64] = 64'h0080_0000_0000_0001; e[127:64] = 64'd1; end
                3: begin dd = 8'd9; s[63:0] = 64'd1; s[127:64] = 64'h0000_0000_0200_0001; e[127:64] = 64'd1; end
                default: begin
                    dd = 8'd2; s[63:0] = 64'd0; s[127:64] = 64'd1;
                    e[63:0] = 64'hFFFF_FFFF_8000_0000; e[127:64] = 64'h0000_0000_8000_0000;
                end
            endcase
            run_txn(dd, s, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (res_q[i] !== e)
                    $display("FAIL directed%0d_ppc%0d got_w0=%h got_w1=%h want_w0=%h want_w1=%h",
                             v, 1 << i, res_q[i][63:0], res_q[i][127:64], e[63:0], e[127:64]);
                else n_pass++;
                n_checks++;
                if (lat_q[i] !== (8 >> i))
                    $display("FAIL directed%0d_latency_ppc%0d got=%0d want=%0d", v, 1 << i, lat_q[i], 8 >> i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_trip(input int n);
        logic [1023:0] s;
        logic [7:0]    dd;
        for (int t = 0; t < n; t++) begin
            s  = rand1024();
            dd = 8'($urandom);
            run_txn(dd, fwd_mix(s, dd[2:0]), 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (res_q[i] !== s)
                    $display("FAIL round_trip t=%0d ppc=%0d d=%0d got_w0=%h want_w0=%h",
                             t, 1 << i, dd, res_q[i][63:0], s[63:0]);
                else n_pass++;
                n_checks++;
                if (lat_q[i] !== (8 >> i))
                    $display("FAIL rt_latency t=%0d ppc=%0d got=%0d want=%0d", t, 1 << i, lat_q[i], 8 >> i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1023:0] s;
        logic [7:0]    dd;
        logic          bad;
        s  = rand1024();
        dd = 8'($urandom);
        run_txn(dd, fwd_mix(s, dd[2:0]), 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (res_q[i] !== s) $display("FAIL bp_result ppc=%0d got_w0=%h want_w0=%h", 1 << i, res_q[i][63:0], s[63:0]);
            else n_pass++;
        end
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'($urandom);
            state_in = rand1024();
            d        = 8'($urandom);
            @(posedge clk); #1;
            bad = (in_ready !== 4'h0) || (out_valid !== 4'hF);
            for (int i = 0; i < 4; i++) if (state_out[i] !== s) bad = 1'b1;
            n_checks++;
            if (bad) $display("FAIL bp_hold k=%0d in_ready=%b want=0000 out_valid=%b want=1111 w0=%h want=%h",
                              k, in_ready, out_valid, state_out[0][63:0], s[63:0]);
            else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 4'h0 || in_ready !== 4'hF)
            $display("FAIL bp_release out_valid=%b want=0000 in_ready=%b want=1111", out_valid, in_ready);
        else n_pass++;
        n_checks++;
        if (state_out[0] !== s) $display("FAIL bp_retain got_w0=%h want=%h", state_out[0][63:0], s[63:0]);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 4'h0 || in_ready !== 4'hF)
            $display("FAIL bp_single out_valid=%b want=0000 in_ready=%b want=1111", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [1023:0] s;
        logic [7:0]    dd;
        s  = rand1024();
        dd = 8'($urandom);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        d         = dd;
        state_in  = fwd_mix(s, dd[2:0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || state_out[i] !== '0)
                $display("FAIL midop_reset ppc=%0d out_valid=%b want=0 in_ready=%b want=1 w0=%h want=0",
                         1 << i, out_valid[i], in_ready[i], state_out[i][63:0]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_round_trip(3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_trip(200);
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unmix_1024.md
Name: unmix_1024

Overview:
- Inverse of the Threefish-1024 MIX layer, used on the decrypt path of the NexusHash core.
- Accepts one 1024-bit state (16 x 64-bit words) plus round index d.
- Undoes the 8 word-pair MIX operations of round d serially, PAIRS_PER_CYCLE pairs per clock.
- Returns the pre-MIX state over a valid/ready handshake.
- Sits between the inverse-permute stage and the key-subtraction stage.

Parameters:
- PAIRS_PER_CYCLE, 1, number of word pairs inverted per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in and d are valid.
- in_ready  output  1  block can accept a state.
- d  input  8  round index; only d%8 (d[2:0]) is used.
- state_in  input  1024  post-MIX words; word k = state_in[64k+63:64k].
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  1024  recovered pre-MIX words, same layout as state_in.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, state_out=0, pair counter=0.
- Inverse MIX for pair j (0..7):
  - y0 = word 2j, y1 = word 2j+1, R = ROT[d%8][j].
  - x1 = rotate-right(y1 XOR y0, R).
  - x0 = (y0 - x1) mod 2^64.
  - Write x0 to word 2j and x1 to word 2j+1.
- ROT table, row d%8, entries j=0..7:
  - 0: 55 43 37 40 16 22 38 12
  - 1: 25 25 46 13 14 13 52 57
  - 2: 33 8 18 57 21 12 32 54
  - 3: 34 43 25 60 44 9 59 34
  - 4: 28 7 47 48 51 9 35 41
  - 5: 17 6 18 25 43 42 40 15
  - 6: 58 7 32 45 19 18 2 56
  - 7: 47 49 27 58 37 48 53 56
- Pairs are independent, so processing order is free. Counter order is ascending j.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture state_in into the working register and latch d[2:0]; clear the counter; go to BUSY.
- BUSY:
  - in_ready=0. Each clock inverts pairs cnt..cnt+PAIRS_PER_CYCLE-1 in the working register, then cnt += PAIRS_PER_CYCLE.
  - When the last group (j=7 included) is processed, go to DONE on that same edge.
  - Latency: out_valid rises 8/PAIRS_PER_CYCLE clocks after the accepting edge.
  - For PAIRS_PER_CYCLE=8 this is exactly 1 clock.
- DONE:
  - out_valid=1 and state_out is the working register, held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE with out_valid=0.
  - in_ready goes high the cycle after the handshake. There is no same-cycle drain+accept.
- Inputs d and state_in are ignored outside the IDLE accept edge. Changing them mid-operation has no effect.
- in_valid while busy or done is held off by in_ready=0. Nothing is dropped or corrupted.
- Arithmetic:
  - Subtraction wraps modulo 2^64.
  - A rotation amount of 0 never occurs (table minimum is 2), but the rotator must still handle R=0 as identity.
- Reset asserted at any time (mid-BUSY, or in DONE with out_ready low) returns all state to reset values immediately. The in-flight state is discarded.
- state_out retains the last result after the handshake until the next DONE. Consumers must qualify it with out_valid.
- Composition with the forward MIX is identity: forward(unmix(s,d),d)=s and unmix(forward(s,d),d)=s for all s and d.

Test Plan:
- Single pair, zero operand: d=0, word0=1, word1=1, other words 0 -> out_valid after 8 clocks (PAIRS_PER_CYCLE=1); word0=1, word1=0, rest 0.
- Single pair, rotation check: d=0, word0=1, word1=0x0080000000000001 -> word0=0, word1=1. Repeat with d=8 using row 0 and with d=9 using row 1 (R=25).
- Round-trip: 200 random 1024-bit states and random d through a forward-MIX reference model and then this block -> state_out equals the original. Run for PAIRS_PER_CYCLE 1, 2, 4 and 8; latency must be 8, 4, 2 and 1 respectively.
- Backpressure: hold out_ready=0 for 20 clocks in DONE, toggle in_valid and state_in -> in_ready=0, state_out stable, out_valid=1. Release -> exactly one transfer, then in_ready=1 the next cycle.
- Reset mid-op: assert rst_n=0 asynchronously at BUSY cnt=3 -> out_valid=0, in_ready=1, state_out=0 without waiting for a clock. The next accepted state yields the correct result.
- Wrap-around subtraction: y0=0, y1=1, d=2, j=0 (R=33) -> x1=ror(1,33)=0x0000000080000000, x0=0xFFFFFFFF80000000.
